// File: rtl/cmos_sw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmos_sw_pkg : gate states and {nctrl, pctrl} pair constants | rev 1.0
// ---------------------------------------------------------------------------
package cmos_sw_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RISE = 2'd1,
      ON   = 2'd2,
      FALL = 2'd3
   } gate_state_e;

   localparam logic [1:0] CTRL_OFF = 2'b01;
   localparam logic [1:0] CTRL_MID = 2'b11;
   localparam logic [1:0] CTRL_ON  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sw_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sw_timer : loadable down counter that saturates at zero | rev 1.0
// ---------------------------------------------------------------------------
module sw_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cmos_gate_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmos_gate_ctrl : skewed, dwell-limited transmission-gate driver | rev 1.0
// ---------------------------------------------------------------------------
module cmos_gate_ctrl
   import cmos_sw_pkg::*;
#(
   parameter int SKEW  = 2,
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_on,
   output logic req_ready,
   output logic nctrl,
   output logic pctrl,
   output logic gate_on,
   output logic busy
);

   localparam int MAX_T = (SKEW > DWELL) ? SKEW : DWELL;
   localparam int CNT_W = $clog2(MAX_T + 1);

   gate_state_e      state_q;
   gate_state_e      state_d;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic [CNT_W-1:0] timer_cnt;
   logic             timer_zero;
   logic             accept;
   logic [1:0]       ctrl;

   sw_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .load_val(load_val),
      .cnt     (timer_cnt),
      .zero    (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
      end else begin
         state_q <= state_d;
      end
   end

   assign accept = req_valid && req_ready;

   // Same-level requests are accepted but fall through without a timer load.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = CNT_W'(SKEW - 1);
      ctrl     = CTRL_OFF;
      unique case (state_q)
         OFF: begin
            ctrl = CTRL_OFF;
            if (accept && req_on) begin
               state_d = RISE;
               load    = 1'b1;
            end
         end
         RISE: begin
            ctrl = CTRL_MID;
            if (timer_zero) begin
               state_d  = ON;
               load     = 1'b1;
               load_val = CNT_W'(DWELL);
            end
         end
         ON: begin
            ctrl = CTRL_ON;
            if (accept && !req_on) begin
               state_d = FALL;
               load    = 1'b1;
            end
         end
         FALL: begin
            ctrl = CTRL_MID;
            if (timer_zero) begin
               state_d  = OFF;
               load     = 1'b1;
               load_val = CNT_W'(DWELL);
            end
         end
         default: begin
            state_d = OFF;
         end
      endcase
   end

   assign {nctrl, pctrl} = ctrl;
   assign req_ready      = ((state_q == OFF) || (state_q == ON)) && (timer_cnt == '0);
   assign gate_on        = (state_q == ON);
   assign busy           = (state_q == RISE) || (state_q == FALL);

   a_never_both_conduct_off: assert property (@(posedge clk) disable iff (rst)
      !(nctrl == 1'b0 && pctrl == 1'b0));

endmodule
`default_nettype wire

// File: tb/tb_cmos_gate_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmos_gate_ctrl : directed scenarios plus random stream vs. timeline model
// ---------------------------------------------------------------------------
module tb_cmos_gate_ctrl;

   localparam int SKEW  = 2;
   localparam int DWELL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0;
   logic req_on = 1'b0;
   logic req_ready, nctrl, pctrl, gate_on, busy;
   logic [4:0] outs;

   int checks = 0;
   int passed = 0;

   // {nctrl, pctrl, gate_on, busy, req_ready}
   localparam logic [4:0] O_IDLE_OFF = 5'b01001;
   localparam logic [4:0] O_DWELL_OFF = 5'b01000;
   localparam logic [4:0] O_MID = 5'b11010;
   localparam logic [4:0] O_DWELL_ON = 5'b10100;
   localparam logic [4:0] O_IDLE_ON = 5'b10101;

   cmos_gate_ctrl #(
      .SKEW (SKEW),
      .DWELL(DWELL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_on   (req_on),
      .req_ready(req_ready),
      .nctrl    (nctrl),
      .pctrl    (pctrl),
      .gate_on  (gate_on),
      .busy     (busy)
   );

   assign outs = {nctrl, pctrl, gate_on, busy, req_ready};

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (nctrl === 1'b0 && pctrl === 1'b0)
            $display("FAIL never_00: nctrl=%b pctrl=%b required not both 0", nctrl, pctrl);
         else
            passed++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL reset: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
      tick();
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL reset_idle: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
   endtask

   task automatic test_turn_on();
      logic [4:0] exp;
      req_valid = 1'b1;
      req_on = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int s = 0; s <= SKEW + DWELL; s++) begin
         exp = (s < SKEW) ? O_MID : ((s < SKEW + DWELL) ? O_DWELL_ON : O_IDLE_ON);
         checks++;
         if (outs !== exp) $display("FAIL turn_on[%0d]: got %b required %b", s, outs, exp);
         else passed++;
         if (s != SKEW + DWELL) tick();
      end
   endtask

   task automatic test_turn_off();
      logic [4:0] exp;
      req_valid = 1'b1;
      req_on = 1'b0;
      tick();
      req_valid = 1'b0;
      for (int s = 0; s <= SKEW + DWELL; s++) begin
         exp = (s < SKEW) ? O_MID : ((s < SKEW + DWELL) ? O_DWELL_OFF : O_IDLE_OFF);
         checks++;
         if (outs !== exp) $display("FAIL turn_off[%0d]: got %b required %b", s, outs, exp);
         else passed++;
         if (s != SKEW + DWELL) tick();
      end
   endtask

   task automatic test_back_pressure();
      logic [4:0] exp;
      req_valid = 1'b1;
      req_on = 1'b1;
      tick();
      req_on = 1'b0;
      for (int s = 0; s <= SKEW + DWELL; s++) begin
         exp = (s < SKEW) ? O_MID : ((s < SKEW + DWELL) ? O_DWELL_ON : O_IDLE_ON);
         checks++;
         if (outs !== exp) $display("FAIL back_pressure[%0d]: got %b required %b", s, outs, exp);
         else passed++;
         tick();
      end
      checks++;
      if (outs !== O_MID) $display("FAIL bp_fall_start: got %b required %b", outs, O_MID);
      else passed++;
      req_valid = 1'b0;
      for (int s = 0; s < SKEW + DWELL; s++) tick();
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL bp_settle: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
   endtask

   task automatic test_redundant();
      req_valid = 1'b1;
      req_on = 1'b0;
      tick();
      req_valid = 1'b0;
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL redundant: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
      tick();
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL redundant_hold: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
   endtask

   task automatic test_reset_mid_rise();
      req_valid = 1'b1;
      req_on = 1'b1;
      tick();
      req_valid = 1'b0;
      checks++;
      if (outs !== O_MID) $display("FAIL mid_rise_pre: got %b required %b", outs, O_MID);
      else passed++;
      tick();
      rst = 1'b1;
      req_valid = 1'b1;
      req_on = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = 1'b0;
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL mid_rise_reset: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
      tick();
      checks++;
      if (outs !== O_IDLE_OFF) $display("FAIL mid_rise_discard: got %b required %b", outs, O_IDLE_OFF);
      else passed++;
   endtask

   // Model: a changing accept at edge k means mid outputs for edges k..k+SKEW-1,
   // stable target from k+SKEW, ready again from k+SKEW+DWELL.
   task automatic test_random();
      int   n, k;
      bit   have, tgt, v, o, r, m_busy, m_rdy;
      logic [4:0] exp;
      rst = 1'b1;
      req_valid = 1'b0;
      tick();
      rst = 1'b0;
      n = 0; k = 0; have = 1'b0; tgt = 1'b0;
      for (int i = 0; i < 500; i++) begin
         m_busy = have && (n < k + SKEW);
         m_rdy  = !m_busy && (!have || (n >= k + SKEW + DWELL));
         exp = m_busy ? O_MID : {tgt, !tgt, tgt, 1'b0, m_rdy};
         checks++;
         if (outs !== exp) $display("FAIL random[%0d]: got %b required %b", i, outs, exp);
         else passed++;
         v = ($urandom_range(0, 9) < 6);
         o = $urandom_range(0, 1) == 1;
         r = ($urandom_range(0, 99) == 0);
         req_valid = v;
         req_on = o;
         rst = r;
         tick();
         n++;
         if (r) begin
            have = 1'b0;
            tgt = 1'b0;
         end else if (v && m_rdy && (o != tgt)) begin
            have = 1'b1;
            k = n;
            tgt = o;
         end
      end
      rst = 1'b0;
      req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_turn_on();
      test_turn_off();
      test_back_pressure();
      test_redundant();
      test_reset_mid_rise();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
